// File: rtl/prog_mem_ctrl_pkg.sv
// ============================================================================
//  Module   : prog_mem_ctrl_pkg
//  Brief    : Shared CPU types: program-memory FSM states, instruction width
//             and the fetch range-check helper.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_mem_ctrl_pkg;

    localparam int c_INST_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RESP = 2'd2
    } prog_state_e;

    // All operands are 17 bits wide so that addr+1 can never wrap to zero.
    function automatic logic fetch_error(
        input logic [15:0] addr,
        input logic [16:0] count,
        input logic [16:0] depth
    );
        logic [16:0] a17;
        logic [16:0] a17_next;
        a17      = {1'b0, addr};
        a17_next = a17 + 17'd1;
        return addr[0] || (a17_next >= count) || (a17 >= depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/prog_byte_ram.sv
// ============================================================================
//  Module   : prog_byte_ram
//  Brief    : Byte-wide program storage, one synchronous write port and two
//             combinational read ports. Contents are not reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_byte_ram #(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [7:0]        rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [7:0]        rdata_b
);

    logic [7:0] r_mem [DEPTH_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata_a = r_mem[raddr_a];
    assign rdata_b = r_mem[raddr_b];

endmodule

`default_nettype wire

// File: rtl/prog_mem_ctrl.sv
// ============================================================================
//  Module   : prog_mem_ctrl
//  Brief    : Program memory controller: byte-stream loader plus 16-bit
//             little-endian instruction fetch with range/alignment checking.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_mem_ctrl
    import prog_mem_ctrl_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic                load_valid,
    input  logic [7:0]          load_byte,
    output logic                load_ready,
    input  logic                load_end,
    output logic [ADDR_W:0]     load_count,
    input  logic                fetch_req,
    input  logic [15:0]         fetch_addr,
    output logic                fetch_ready,
    output logic                fetch_valid,
    output logic [c_INST_W-1:0] fetch_inst,
    output logic                fetch_err
);

    localparam logic [1:0]      c_IDLE   = ST_IDLE;
    localparam logic [1:0]      c_LOAD   = ST_LOAD;
    localparam logic [1:0]      c_RESP   = ST_RESP;
    localparam logic [ADDR_W:0] c_LAST   = (ADDR_W+1)'(DEPTH_BYTES - 1);
    localparam logic [16:0]     c_DEPTH  = 17'(DEPTH_BYTES);

    logic [1:0]          r_state;
    logic [ADDR_W:0]     r_wptr;
    logic [ADDR_W:0]     r_load_count;
    logic [15:0]         r_addr;
    logic [c_INST_W-1:0] r_inst_hold;
    logic                r_err_hold;

    logic                w_wr_en;
    logic                w_last;
    logic [ADDR_W:0]     w_wptr_next;
    logic                w_resp;
    logic [ADDR_W-1:0]   w_raddr_a;
    logic [ADDR_W-1:0]   w_raddr_b;
    logic [7:0]          w_rdata_a;
    logic [7:0]          w_rdata_b;
    logic                w_err;
    logic [c_INST_W-1:0] w_inst;

    assign w_wr_en     = (r_state == c_LOAD) && load_valid;
    assign w_last      = w_wr_en && (r_wptr == c_LAST);
    assign w_wptr_next = r_wptr + {{ADDR_W{1'b0}}, w_wr_en};

    assign w_raddr_a = r_addr[ADDR_W-1:0];
    assign w_raddr_b = w_raddr_a + {{(ADDR_W-1){1'b0}}, 1'b1};

    prog_byte_ram #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .ADDR_W      (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (w_wr_en),
        .waddr   (r_wptr[ADDR_W-1:0]),
        .wdata   (load_byte),
        .raddr_a (w_raddr_a),
        .rdata_a (w_rdata_a),
        .raddr_b (w_raddr_b),
        .rdata_b (w_rdata_b)
    );

    assign w_err  = fetch_error(r_addr, 17'(r_load_count), c_DEPTH);
    assign w_inst = w_err ? '0 : {w_rdata_b, w_rdata_a};

    // A reset arriving during RESP must suppress the strobe in that same cycle.
    assign w_resp = (r_state == c_RESP) && !rst;

    assign load_ready  = (r_state == c_LOAD);
    assign fetch_ready = (r_state == c_IDLE);
    assign fetch_valid = w_resp;
    assign fetch_inst  = w_resp ? w_inst : r_inst_hold;
    assign fetch_err   = w_resp ? w_err  : r_err_hold;
    assign load_count  = r_load_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_wptr       <= '0;
            r_load_count <= '0;
            r_addr       <= '0;
            r_inst_hold  <= '0;
            r_err_hold   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (load_start) begin
                        r_state <= c_LOAD;
                        r_wptr  <= '0;
                    end else if (fetch_req) begin
                        r_addr  <= fetch_addr;
                        r_state <= c_RESP;
                    end
                end
                c_LOAD: begin
                    r_wptr <= w_wptr_next;
                    if (load_end || w_last) begin
                        r_load_count <= w_wptr_next;
                        r_state      <= c_IDLE;
                    end
                end
                c_RESP: begin
                    r_inst_hold <= w_inst;
                    r_err_hold  <= w_err;
                    r_state     <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prog_mem_ctrl.sv
// ============================================================================
//  Module   : tb_prog_mem_ctrl
//  Brief    : Directed self-checking bench for prog_mem_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_mem_ctrl;

    localparam int DEPTH_BYTES = 256;
    localparam int ADDR_W      = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic [7:0]        load_byte = '0;
    logic              load_ready;
    logic              load_end = 1'b0;
    logic [ADDR_W:0]   load_count;
    logic              fetch_req = 1'b0;
    logic [15:0]       fetch_addr = '0;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [15:0]       fetch_inst;
    logic              fetch_err;

    int n_vec = 0;
    int n_err = 0;

    prog_mem_ctrl #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_byte   (load_byte),
        .load_ready  (load_ready),
        .load_end    (load_end),
        .load_count  (load_count),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_inst  (fetch_inst),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bytes(input logic [7:0] b[$], input bit end_on_last);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("load_ready_in_load", load_ready, 1);
        foreach (b[i]) begin
            load_valid = 1'b1;
            load_byte  = b[i];
            load_end   = end_on_last && (i == b.size() - 1);
            tick();
        end
        load_valid = 1'b0;
        load_end   = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [15:0] addr,
                         input logic [15:0] exp_inst, input logic exp_err);
        for (int k = 0; k < 20 && !fetch_ready; k++) tick();
        chk({tag, "_ready"}, fetch_ready, 1);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_req  = 1'b0;
        chk({tag, "_valid"}, fetch_valid, 1);
        chk({tag, "_inst"},  fetch_inst,  exp_inst);
        chk({tag, "_err"},   fetch_err,   exp_err);
        tick();
        chk({tag, "_valid_drop"}, fetch_valid, 0);
        chk({tag, "_inst_hold"},  fetch_inst,  exp_inst);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];

        // Reset state
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_fetch_ready", fetch_ready, 1);
        chk("rst_load_ready",  load_ready,  0);
        chk("rst_load_count",  load_count,  0);
        chk("rst_fetch_valid", fetch_valid, 0);
        chk("rst_fetch_inst",  fetch_inst,  0);
        chk("rst_fetch_err",   fetch_err,   0);

        // 4-byte load, load_end coincides with the last byte
        q = '{8'h50, 8'h00, 8'h12, 8'h34};
        load_bytes(q, 1'b1);
        chk("l4_count", load_count, 4);
        chk("l4_idle",  fetch_ready, 1);
        fetch("f0", 16'd0, 16'h0050, 1'b0);
        fetch("f2", 16'd2, 16'h3412, 1'b0);
        fetch("f1", 16'd1, 16'h0000, 1'b1);
        fetch("f4", 16'd4, 16'h0000, 1'b1);
        fetch("f3", 16'd3, 16'h0000, 1'b1);
        fetch("fbig", 16'hFFFE, 16'h0000, 1'b1);

        // Zero-byte load
        load_start = 1'b1; tick(); load_start = 1'b0;
        load_end = 1'b1; tick(); load_end = 1'b0;
        chk("l0_count", load_count, 0);
        fetch("l0_f0", 16'd0, 16'h0000, 1'b1);

        // Reset after 3 bytes of a load
        q = '{8'h50, 8'h00, 8'h12, 8'h34};
        load_bytes(q, 1'b1);
        load_start = 1'b1; tick(); load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_byte = 8'(8'h20 + i); tick();
        end
        load_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstmid_count", load_count, 0);
        chk("rstmid_ready", fetch_ready, 1);
        fetch("rstmid_f0", 16'd0, 16'h0000, 1'b1);

        // load_start wins over fetch_req; load_start inside LOAD is ignored
        load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 16'd0;
        tick();
        load_start = 1'b0; fetch_req = 1'b0;
        chk("pri_load_ready",  load_ready,  1);
        chk("pri_fetch_valid", fetch_valid, 0);
        chk("pri_fetch_ready", fetch_ready, 0);
        load_valid = 1'b1; load_byte = 8'hAB; tick();
        load_start = 1'b1; load_byte = 8'hCD; tick();
        load_start = 1'b0; load_byte = 8'hEF; tick();
        load_valid = 1'b0;
        chk("pri_still_loading", fetch_ready, 0);
        load_end = 1'b1; tick(); load_end = 1'b0;
        chk("pri_count", load_count, 3);
        fetch("pri_f0", 16'd0, 16'hCDAB, 1'b0);
        fetch("pri_f2", 16'd2, 16'h0000, 1'b1);

        // Full load with no load_end: byte i = (7*i+3) mod 256
        q.delete();
        for (int i = 0; i < DEPTH_BYTES; i++) q.push_back(8'((7 * i + 3) & 255));
        load_bytes(q, 1'b0);
        chk("full_load_ready", load_ready, 0);
        chk("full_count",      load_count, 256);
        chk("full_idle",       fetch_ready, 1);
        fetch("full_f254", 16'd254, 16'hFCF5, 1'b0);
        fetch("full_f256", 16'd256, 16'h0000, 1'b1);

        // load_valid outside LOAD must not write
        load_valid = 1'b1; load_byte = 8'hEE; tick(); load_valid = 1'b0;
        fetch("ign_f0", 16'd0, 16'h0A03, 1'b0);

        // Back-to-back fetch_req held high
        fetch_req = 1'b1; fetch_addr = 16'd0;
        tick();
        chk("b2b_v0",    fetch_valid, 1);
        chk("b2b_i0",    fetch_inst,  16'h0A03);
        chk("b2b_rdy0",  fetch_ready, 0);
        fetch_addr = 16'd2;
        tick();
        chk("b2b_gap",   fetch_valid, 0);
        chk("b2b_rdy1",  fetch_ready, 1);
        tick();
        chk("b2b_v1",    fetch_valid, 1);
        chk("b2b_i1",    fetch_inst,  16'h1811);
        fetch_addr = 16'd255;
        tick();
        chk("b2b_gap2",  fetch_valid, 0);
        tick();
        chk("b2b_v2",    fetch_valid, 1);
        chk("b2b_e2",    fetch_err,   1);
        fetch_req = 1'b0;
        tick();

        // Reset while a response is pending
        fetch_req = 1'b1; fetch_addr = 16'd0;
        tick();
        fetch_req = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstresp_valid", fetch_valid, 0);
        tick();
        rst = 1'b0;
        chk("rstresp_valid2", fetch_valid, 0);
        chk("rstresp_inst",   fetch_inst,  0);
        chk("rstresp_ready",  fetch_ready, 1);
        chk("rstresp_count",  load_count,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
